// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Contents:
//   state_t      - 4-bit control FSM state encoding
//   OP_*         - instruction opcodes (IR[31:26]) recognised by the FSM
//   ALUOP_*      - 2-bit ALU-op codes understood by the ALU-control decoder
//   SRCB_*       - ALU B operand select codes
//   PCSRC_*      - PC source select codes
//   err_code_t   - fatal error codes reported on error_code
//   is_mem_state - true for states that access the shared memory
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ANDI_EXEC = 4'd11,
    S_IMM_WB    = 4'd12,
    S_ERROR     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [1:0] SRCB_REG      = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'b00,
    ERR_ILLEGAL_OP  = 2'b01,
    ERR_MEM_TIMEOUT = 2'b10
  } err_code_t;

  function automatic logic is_mem_state(input state_t s);
    logic r;
    case (s)
      S_FETCH, S_MEM_READ, S_MEM_WRITE: r = 1'b1;
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Memory wait timer for the multicycle control FSM.
// Counts cycles spent in a memory state with mem_ready low and flags a
// timeout when the count has reached MEM_WAIT_MAX and the memory is still
// not ready. 2**CNT_W must exceed MEM_WAIT_MAX.
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset (clears the count)
//   in_mem_i     FSM is currently in a memory-access state
//   clear_i      FSM changes state this cycle (restarts the count)
//   mem_ready_i  memory completes the access this cycle
//   timeout_o    wait limit reached with memory still not ready
module mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_mem_i,
  input  logic clear_i,
  input  logic mem_ready_i,
  output logic timeout_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MEM_WAIT_MAX);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any state change restarts the count, so each entry into a memory state
  // begins at zero. Counting stops at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (in_mem_i && !mem_ready_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // mem_ready on the limit cycle completes the access, so it masks timeout.
  assign timeout_o = in_mem_i && !mem_ready_i && (cnt_q == MAX_CNT);

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch / decode / execute / memory / writeback, handshakes with
// the shared instruction/data memory via mem_ready, and drives every mux
// select and write enable of the datapath. Fatal conditions (illegal
// opcode, memory timeout) park the FSM in ERROR until reset.
// Ports:
//   clk, rst_n               clock; asynchronous active-low reset
//   opcode                   IR[31:26]
//   zero                     ALU zero flag (beq)
//   mem_ready                memory finished the current access
//   pc_en, i_or_d, mem_read, mem_write, ir_write, mdr_write,
//   reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
//   alu_op, pc_source        datapath controls
//   instr_done               pulse on the last cycle of an instruction
//   error, error_code        sticky fatal error flag and its cause
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       error,
  output logic [1:0] error_code
);

  state_t    state_q, state_d;
  err_code_t err_q, err_d;
  logic      timeout;

  mem_wait_timer #(
    .MEM_WAIT_MAX (MEM_WAIT_MAX),
    .CNT_W        (CNT_W)
  ) u_mem_wait_timer (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_mem_i    (is_mem_state(state_q)),
    .clear_i     (state_d != state_q),
    .mem_ready_i (mem_ready),
    .timeout_o   (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode the current state. The whole decode is gated by rst_n so
  // that the FETCH outputs do not appear while reset is held.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    pc_en      = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mdr_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_op     = ALUOP_ADD;
    pc_source  = PCSRC_ALU;
    instr_done = 1'b0;
    error      = 1'b0;
    error_code = ERR_NONE;

    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          // PC + 4 is computed while the instruction is read.
          mem_read  = 1'b1;
          i_or_d    = 1'b0;
          alu_src_a = 1'b0;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALUOP_ADD;
          pc_source = PCSRC_ALU;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_en    = 1'b1;
            state_d  = S_DECODE;
          end else if (timeout) begin
            state_d = S_ERROR;
            err_d   = ERR_MEM_TIMEOUT;
          end
        end

        S_DECODE: begin
          // Branch target is precomputed here into ALUOut.
          alu_src_a = 1'b0;
          alu_src_b = SRCB_IMM_SHL2;
          alu_op    = ALUOP_ADD;
          case (opcode)
            OP_RTYPE:     state_d = S_EXECUTE;
            OP_LW, OP_SW: state_d = S_MEM_ADDR;
            OP_BEQ:       state_d = S_BRANCH;
            OP_J:         state_d = S_JUMP;
            OP_ADDI:      state_d = S_ADDI_EXEC;
            OP_ANDI:      state_d = S_ANDI_EXEC;
            default: begin
              state_d = S_ERROR;
              err_d   = ERR_ILLEGAL_OP;
            end
          endcase
        end

        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_ADD;
          // IR cannot change after FETCH, so only lw/sw can reach here; any
          // other value indicates corruption and is treated as illegal.
          if (opcode == OP_LW) begin
            state_d = S_MEM_READ;
          end else if (opcode == OP_SW) begin
            state_d = S_MEM_WRITE;
          end else begin
            state_d = S_ERROR;
            err_d   = ERR_ILLEGAL_OP;
          end
        end

        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (mem_ready) begin
            mdr_write = 1'b1;
            state_d   = S_MEM_WB;
          end else if (timeout) begin
            state_d = S_ERROR;
            err_d   = ERR_MEM_TIMEOUT;
          end
        end

        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          reg_dst    = 1'b0;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end

        S_MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else if (timeout) begin
            state_d = S_ERROR;
            err_d   = ERR_MEM_TIMEOUT;
          end
        end

        S_EXECUTE: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_REG;
          alu_op    = ALUOP_FUNCT;
          state_d   = S_R_WB;
        end

        S_R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          mem_to_reg = 1'b0;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end

        S_BRANCH: begin
          // A - B sets zero; the PC takes the precomputed target if equal.
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_REG;
          alu_op     = ALUOP_SUB;
          pc_source  = PCSRC_ALUOUT;
          pc_en      = zero;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end

        S_JUMP: begin
          pc_source  = PCSRC_JUMP;
          pc_en      = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end

        S_ADDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_ADD;
          state_d   = S_IMM_WB;
        end

        S_ANDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_AND;
          state_d   = S_IMM_WB;
        end

        S_IMM_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b0;
          mem_to_reg = 1'b0;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end

        S_ERROR: begin
          // Terminal: only reset leaves this state.
          error      = 1'b1;
          error_code = err_q;
        end

        default: begin
          // Unused encodings fall into ERROR rather than wandering.
          state_d = S_ERROR;
          err_d   = ERR_ILLEGAL_OP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam int MEM_WAIT_MAX = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, mdr_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       instr_done, error;
  logic [1:0] error_code;

  multicycle_control #(
    .MEM_WAIT_MAX (MEM_WAIT_MAX),
    .CNT_W        (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .mdr_write  (mdr_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .instr_done (instr_done),
    .error      (error),
    .error_code (error_code)
  );

  always #5 clk = ~clk;

  // Instruction phases as described behaviourally; PH_RST means reset held.
  typedef enum {PH_RST, PH_F, PH_D, PH_MA, PH_MR, PH_MWB, PH_MW, PH_EX,
                PH_RWB, PH_BR, PH_J, PH_AE, PH_NE, PH_IWB, PH_ERR} ph_t;

  typedef struct packed {
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write, mdr_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, error;
    logic [1:0] error_code;
  } ctrl_t;

  typedef struct {
    logic [5:0] op;
    logic       rdy;
    logic       z;
    ctrl_t      exp;
  } vec_t;

  localparam logic [5:0] LW = 6'h23, SW = 6'h2b, RT = 6'h00, BEQ = 6'h04;
  localparam logic [5:0] JMP = 6'h02, ADDI = 6'h08, ANDI = 6'h0c, BAD = 6'h3f;

  ctrl_t act;
  assign act = {pc_en, i_or_d, mem_read, mem_write, ir_write, mdr_write,
                reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, instr_done, error, error_code};

  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t tbl[$];

  // Control outputs required in each phase, with mem_ready and zero applied.
  function automatic ctrl_t expect_ctrl(input ph_t ph, input logic rdy,
                                        input logic z, input logic [1:0] code);
    ctrl_t c;
    c = '0;
    case (ph)
      PH_F:   begin c.mem_read = 1'b1; c.alu_src_b = 2'b01;
                    c.ir_write = rdy; c.pc_en = rdy; end
      PH_D:   c.alu_src_b = 2'b11;
      PH_MA:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      PH_MR:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; c.mdr_write = rdy; end
      PH_MWB: begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1; end
      PH_MW:  begin c.mem_write = 1'b1; c.i_or_d = 1'b1; c.instr_done = rdy; end
      PH_EX:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      PH_RWB: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.instr_done = 1'b1; end
      PH_BR:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_source = 2'b01;
                    c.pc_en = z; c.instr_done = 1'b1; end
      PH_J:   begin c.pc_source = 2'b10; c.pc_en = 1'b1; c.instr_done = 1'b1; end
      PH_AE:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      PH_NE:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
      PH_IWB: begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
      PH_ERR: begin c.error = 1'b1; c.error_code = code; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic void add(input logic [5:0] op, input logic rdy,
                              input logic z, input ph_t ph);
    vec_t v;
    v.op  = op;
    v.rdy = rdy;
    v.z   = z;
    v.exp = expect_ctrl(ph, rdy, z, 2'b00);
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input ctrl_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h at t=%0t", name, act, exp, $time);
  endtask

  // Entered at posedge+1: drive inputs, compare at negedge, advance a cycle.
  task automatic cyc(input string name, input logic [5:0] op, input logic rdy,
                     input logic z, input ctrl_t exp);
    opcode    = op;
    mem_ready = rdy;
    zero      = z;
    @(negedge clk);
    check(name, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input string name);
    mem_ready = 1'b1;
    opcode    = LW;
    rst_n     = 1'b0;
    #1;
    check(name, expect_ctrl(PH_RST, 1'b1, 1'b0, 2'b00));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference model: an instruction is its list of phases; each memory phase
  // sees `w` cycles of mem_ready low before completing.
  task automatic run_instr(input string name, input logic [5:0] op,
                           input int wf, input int wm);
    ph_t seq[$];
    case (op)
      LW:      seq = '{PH_F, PH_D, PH_MA, PH_MR, PH_MWB};
      SW:      seq = '{PH_F, PH_D, PH_MA, PH_MW};
      RT:      seq = '{PH_F, PH_D, PH_EX, PH_RWB};
      BEQ:     seq = '{PH_F, PH_D, PH_BR};
      JMP:     seq = '{PH_F, PH_D, PH_J};
      ADDI:    seq = '{PH_F, PH_D, PH_AE, PH_IWB};
      default: seq = '{PH_F, PH_D, PH_NE, PH_IWB};
    endcase
    foreach (seq[k]) begin
      logic z;
      z = 1'($urandom_range(0, 1));
      if (seq[k] == PH_F || seq[k] == PH_MR || seq[k] == PH_MW) begin
        int w;
        w = (seq[k] == PH_F) ? wf : wm;
        for (int c = 0; c < w; c++)
          cyc(name, op, 1'b0, z, expect_ctrl(seq[k], 1'b0, z, 2'b00));
        cyc(name, op, 1'b1, z, expect_ctrl(seq[k], 1'b1, z, 2'b00));
      end else begin
        logic r;
        r = 1'($urandom_range(0, 1));
        cyc(name, op, r, z, expect_ctrl(seq[k], r, z, 2'b00));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] legal [7];
    legal = '{RT, LW, SW, BEQ, JMP, ADDI, ANDI};

    rst_n     = 1'b0;
    opcode    = LW;
    mem_ready = 1'b1;
    zero      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", expect_ctrl(PH_RST, 1'b1, 1'b0, 2'b00));
    rst_n = 1'b1;

    // Directed table, starting from FETCH right after reset release.
    add(LW, 1, 0, PH_F);   add(LW, 0, 0, PH_D);   add(LW, 1, 0, PH_MA);
    add(LW, 1, 0, PH_MR);  add(LW, 0, 0, PH_MWB);
    add(RT, 1, 0, PH_F);   add(RT, 1, 0, PH_D);   add(RT, 0, 0, PH_EX);
    add(RT, 1, 0, PH_RWB);
    add(BEQ, 1, 1, PH_F);  add(BEQ, 1, 1, PH_D);  add(BEQ, 1, 1, PH_BR);
    add(BEQ, 1, 0, PH_F);  add(BEQ, 1, 0, PH_D);  add(BEQ, 1, 0, PH_BR);
    add(JMP, 0, 0, PH_F);  add(JMP, 0, 0, PH_F);  add(JMP, 0, 0, PH_F);
    add(JMP, 1, 0, PH_F);  add(JMP, 1, 0, PH_D);  add(JMP, 0, 0, PH_J);
    add(SW, 1, 0, PH_F);   add(SW, 1, 0, PH_D);   add(SW, 1, 0, PH_MA);
    add(SW, 1, 0, PH_MW);
    add(ANDI, 1, 0, PH_F); add(ANDI, 1, 0, PH_D); add(ANDI, 1, 0, PH_NE);
    add(ANDI, 1, 0, PH_IWB);
    add(ADDI, 1, 0, PH_F); add(ADDI, 1, 0, PH_D); add(ADDI, 1, 0, PH_AE);
    add(ADDI, 1, 0, PH_IWB);
    for (int i = 0; i < tbl.size(); i++)
      cyc($sformatf("vec%0d", i), tbl[i].op, tbl[i].rdy, tbl[i].z, tbl[i].exp);

    // mem_ready arriving exactly at the wait limit completes the access.
    run_instr("lw_wait_limit", LW, 0, MEM_WAIT_MAX);
    run_instr("sw_fetch_limit", SW, MEM_WAIT_MAX, 0);

    // Timeout in MEM_WRITE: MEM_WAIT_MAX+1 cycles of mem_ready low.
    cyc("to_f", SW, 1'b1, 1'b0, expect_ctrl(PH_F, 1'b1, 1'b0, 2'b00));
    cyc("to_d", SW, 1'b1, 1'b0, expect_ctrl(PH_D, 1'b1, 1'b0, 2'b00));
    cyc("to_ma", SW, 1'b1, 1'b0, expect_ctrl(PH_MA, 1'b1, 1'b0, 2'b00));
    for (int i = 0; i <= MEM_WAIT_MAX; i++)
      cyc("to_mw_wait", SW, 1'b0, 1'b0, expect_ctrl(PH_MW, 1'b0, 1'b0, 2'b00));
    for (int i = 0; i < 3; i++)
      cyc("to_error", legal[i], 1'b1, 1'b1, expect_ctrl(PH_ERR, 1'b1, 1'b1, 2'b10));
    pulse_reset("to_reset_low");
    run_instr("after_timeout_reset", JMP, 0, 0);

    // Illegal opcode in DECODE.
    cyc("ill_f", BAD, 1'b1, 1'b0, expect_ctrl(PH_F, 1'b1, 1'b0, 2'b00));
    cyc("ill_d", BAD, 1'b1, 1'b0, expect_ctrl(PH_D, 1'b1, 1'b0, 2'b00));
    cyc("ill_error", BAD, 1'b1, 1'b0, expect_ctrl(PH_ERR, 1'b1, 1'b0, 2'b01));
    cyc("ill_error_hold", RT, 1'b0, 1'b1, expect_ctrl(PH_ERR, 1'b0, 1'b1, 2'b01));
    pulse_reset("ill_reset_low");
    run_instr("after_illegal_reset", RT, 1, 0);

    // Asynchronous reset in the middle of MEM_READ.
    cyc("ar_f", LW, 1'b1, 1'b0, expect_ctrl(PH_F, 1'b1, 1'b0, 2'b00));
    cyc("ar_d", LW, 1'b1, 1'b0, expect_ctrl(PH_D, 1'b1, 1'b0, 2'b00));
    cyc("ar_ma", LW, 1'b1, 1'b0, expect_ctrl(PH_MA, 1'b1, 1'b0, 2'b00));
    mem_ready = 1'b0;
    #2;
    check("ar_mr", expect_ctrl(PH_MR, 1'b0, 1'b0, 2'b00));
    pulse_reset("ar_reset_low");
    run_instr("after_async_reset", LW, 0, 0);

    // Randomized instruction stream against the phase model.
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      int wf, wm;
      op = legal[$urandom_range(0, 6)];
      wf = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
      wm = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
      run_instr($sformatf("rand%0d_op%02h", n, op), op, wf, wm);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback over several cycles, with a ready handshake to a shared instruction/data memory.
- Drives the 2-bit ALU-op code into the existing ALU-control decoder, using the same encoding: 00 add, 01 sub, 10 R-type funct, 11 and.
- Also drives every mux select and write enable of the datapath, and reports fatal errors.

Parameters:
- MEM_WAIT_MAX, default 15: maximum cycles spent waiting for mem_ready in one memory state before a timeout error.
- CNT_W, default 4: width of the wait counter; must satisfy 2^CNT_W > MEM_WAIT_MAX.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- opcode  in  6  instruction register bits [31:26].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current access this cycle.
- pc_en  out  1  PC load enable.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mdr_write  out  1  memory data register load.
- reg_dst  out  1  destination register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback data select: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- alu_op  out  2  to the ALU-control decoder.
- pc_source  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- error  out  1  sticky; set on entering ERROR.
- error_code  out  2  01 = illegal opcode, 10 = memory timeout, 00 = none.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to FETCH; wait counter and error_code clear to 0.
  - Every output is forced to 0 while rst_n is low, including the FETCH decode.
  - A reset in the middle of an instruction abandons it; no partial write is issued after release.
- Outputs are a decode of the current state. pc_en, ir_write, mdr_write and instr_done are additionally qualified by mem_ready or zero as listed below. Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - If mem_ready: ir_write=1, pc_en=1, next state is DECODE. Otherwise stay.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target).
  - Next state by opcode:
    - 000000 goes to EXECUTE.
    - 100011 and 101011 go to MEM_ADDR.
    - 000100 goes to BRANCH.
    - 000010 goes to JUMP.
    - 001000 goes to ADDI_EXEC.
    - 001100 goes to ANDI_EXEC.
    - Any other opcode goes to ERROR with code 01.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read=1, i_or_d=1. If mem_ready: mdr_write=1, next state is MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state is FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. If mem_ready: instr_done=1, next state is FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next state is R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_en=zero, instr_done=1. Next state is FETCH.
- JUMP: pc_source=10, pc_en=1, instr_done=1. Next state is FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is IMM_WB.
- ANDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11. Next state is IMM_WB.
- IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next state is FETCH.
- ERROR:
  - All control outputs 0; error=1; error_code holds its value.
  - No exit except reset.
- Wait counter (memory states FETCH, MEM_READ, MEM_WRITE):
  - Clears on entry to any memory state.
  - Increments on each cycle in a memory state with mem_ready=0.
  - If the counter equals MEM_WAIT_MAX while mem_ready=0, the next state is ERROR with code 10.
  - mem_ready=1 on that same cycle wins: the access completes and no error is raised.
  - The counter saturates; it never wraps.
- Opcode sampling: opcode is sampled only in DECODE and MEM_ADDR. The IR is stable from DECODE onward because ir_write is asserted only in FETCH.
- Latency with mem_ready tied high:
  - lw: 5 cycles.
  - sw, R-type, addi, andi: 4 cycles.
  - beq, j: 3 cycles.
  - Each memory state adds one cycle per cycle that mem_ready is low.

Decomposition:
- Shared package holds:
  - State encoding constants, 4 bits: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ANDI_EXEC=11, IMM_WB=12, ERROR=15.
  - Opcode constants.
  - ALU-op constants, shared with the ALU-control decoder.
  - Error codes.
- One sub-module: mem_wait_timer, holding the wait counter and the timeout compare.

Test Plan:
- Reset low, then release with mem_ready=1 and opcode=100011 (lw): state sequence FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, FETCH; instr_done pulses once on cycle 5; alu_op is 00 throughout.
- R-type (000000): alu_op=10 in EXECUTE; reg_write=1 with reg_dst=1 on cycle 4; 4-cycle latency.
- beq (000100) with zero=1, then zero=0: pc_en=1 with pc_source=01 in BRANCH for the first, pc_en=0 for the second; 3 cycles each.
- FETCH with mem_ready low for 3 cycles, then high: mem_read held for 4 cycles; ir_write and pc_en only on the 4th; no error.
- mem_ready held low in MEM_WRITE for MEM_WAIT_MAX+1 cycles: ERROR entered, error=1, error_code=10; stays there until rst_n pulses low, then FETCH with error=0.
- Illegal opcode 111111 in DECODE: ERROR, error_code=01. Also assert rst_n low during MEM_READ: all outputs drop to 0 immediately, with no clock edge needed.
